// File: rtl/amp_pwr_seq.sv
// amp_pwr_seq: power and fault sequencer for the class-D amplifier stage.
// Holds the amp in shutdown until the EQ low-frequency queues are full. It
// then runs a timed power-up and a sample-counted unmute. On an amp fault it
// mutes and shuts the amp down, cools down and retries. After MAX_RETRY
// consecutive faults it locks out until clr_fault is pulsed.
//
// state   | enc | meaning
// --------+-----+----------------------------------------------------------
// WAIT_Q  |  0  | amp off and muted, waiting for seq_low
// PWR_UP  |  1  | amp still off, counting STARTUP_CYC clk cycles
// UNMUTE  |  2  | amp on but muted, counting UNMUTE_SMP vld strobes
// RUN     |  3  | amp on and unmuted, normal operation
// FAULT   |  4  | amp off and muted, COOLDOWN_CYC cooldown before retry
// LOCKOUT |  5  | amp off and muted, waiting for clr_fault

module amp_pwr_seq #(
  parameter int unsigned STARTUP_CYC  = 250000,
  parameter int unsigned UNMUTE_SMP   = 64,
  parameter int unsigned COOLDOWN_CYC = 250000,
  parameter int unsigned FLT_FILT     = 4,
  parameter int unsigned MAX_RETRY    = 3,
  parameter int unsigned CNT_W        = 18
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Flt_n,
  input  logic       seq_low,
  input  logic       vld,
  input  logic       clr_fault,
  output logic       sht_dwn,
  output logic       mute,
  output logic [1:0] fault_cnt,
  output logic       lockout,
  output logic [2:0] state
);

  localparam int unsigned SMP_W = $clog2(UNMUTE_SMP + 1);
  localparam int unsigned FLT_W = $clog2(FLT_FILT + 1);

  localparam logic [CNT_W-1:0] STARTUP_LAST = CNT_W'(STARTUP_CYC - 1);
  localparam logic [CNT_W-1:0] COOL_LAST    = CNT_W'(COOLDOWN_CYC - 1);
  localparam logic [SMP_W-1:0] SMP_LAST     = SMP_W'(UNMUTE_SMP - 1);
  localparam logic [SMP_W-1:0] SMP_DONE     = SMP_W'(UNMUTE_SMP);
  localparam logic [FLT_W-1:0] FLT_LAST     = FLT_W'(FLT_FILT - 1);
  localparam logic [FLT_W-1:0] FLT_MAX      = FLT_W'(FLT_FILT);
  localparam logic [1:0]       RETRY_MAX    = 2'(MAX_RETRY);

  typedef enum logic [2:0] {
    WAIT_Q  = 3'd0,
    PWR_UP  = 3'd1,
    UNMUTE  = 3'd2,
    RUN     = 3'd3,
    FAULT   = 3'd4,
    LOCKOUT = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cyc_q, cyc_d;
  logic [SMP_W-1:0]  smp_q, smp_d;
  logic [1:0]        fcnt_q, fcnt_d;
  logic              flt_s1, flt_s2;
  logic [FLT_W-1:0]  flt_cnt;
  logic              flt_det;

  // Two-flop resynchronizer for the asynchronous fault pin (idles high).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flt_s1 <= 1'b1;
      flt_s2 <= 1'b1;
    end else begin
      flt_s1 <= Flt_n;
      flt_s2 <= flt_s1;
    end
  end

  // Glitch filter: count consecutive synced-low cycles, saturating at FLT_FILT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flt_cnt <= '0;
    end else if (flt_s2) begin
      flt_cnt <= '0;
    end else if (flt_cnt != FLT_MAX) begin
      flt_cnt <= flt_cnt + 1'b1;
    end
  end

  // The fault is a level that stays up while the pin is low. It fires in the
  // cycle whose edge brings the count to FLT_FILT, so the FSM acts on that edge.
  // A fault that was already present when power-up starts is still caught.
  assign flt_det = ~flt_s2 && (flt_cnt >= FLT_LAST);

  // State, counter and retry-count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= WAIT_Q;
      cyc_q   <= '0;
      smp_q   <= '0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      smp_q   <= smp_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // Next-state, counter and retry-count logic. Fault detection takes priority.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    smp_d   = smp_q;
    fcnt_d  = fcnt_q;

    case (state_q)
      WAIT_Q: begin
        if (seq_low) state_d = PWR_UP;
      end
      PWR_UP: begin
        if (flt_det)                    state_d = FAULT;
        else if (cyc_q == STARTUP_LAST) state_d = UNMUTE;
        else                            cyc_d   = cyc_q + 1'b1;
      end
      UNMUTE: begin
        if (flt_det) begin
          state_d = FAULT;
        end else if (vld) begin
          if (smp_q == SMP_LAST) state_d = RUN;
          else                   smp_d   = smp_q + 1'b1;
        end
      end
      RUN: begin
        if (flt_det) begin
          state_d = FAULT;
        end else if (vld && (smp_q != SMP_DONE)) begin
          smp_d = smp_q + 1'b1;
          if (smp_q == SMP_LAST) fcnt_d = '0;
        end
      end
      FAULT: begin
        if (fcnt_q == RETRY_MAX) begin
          state_d = LOCKOUT;
        end else if (cyc_q == COOL_LAST) begin
          // Retry only if the pin is released at expiry; otherwise start over.
          if (flt_s2) state_d = WAIT_Q;
          else        cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      LOCKOUT: begin
        if (clr_fault) begin
          state_d = WAIT_Q;
          fcnt_d  = '0;
        end
      end
      default: state_d = WAIT_Q;
    endcase

    if ((state_d == FAULT) && (state_q != FAULT)) begin
      fcnt_d = (fcnt_q == RETRY_MAX) ? fcnt_q : fcnt_q + 2'd1;
    end

    if (state_d != state_q) begin
      cyc_d = '0;
      smp_d = '0;
    end
  end

  // Outputs are registered from the next state so they switch on the transition edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sht_dwn <= 1'b1;
      mute    <= 1'b1;
      lockout <= 1'b0;
    end else begin
      sht_dwn <= !((state_d == UNMUTE) || (state_d == RUN));
      mute    <= (state_d != RUN);
      lockout <= (state_d == LOCKOUT);
    end
  end

  assign fault_cnt = fcnt_q;
  assign state     = state_q;

endmodule

// File: tb/tb_amp_pwr_seq.sv
// Directed bench for amp_pwr_seq using short timer settings. It covers
// power-up, glitch rejection, retry, persistent fault, async reset and lockout.

`timescale 1ns/1ps

module tb_amp_pwr_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       Flt_n;
  logic       seq_low;
  logic       vld;
  logic       clr_fault;
  logic       sht_dwn;
  logic       mute;
  logic [1:0] fault_cnt;
  logic       lockout;
  logic [2:0] state;

  int n_tests = 0;
  int n_fail  = 0;

  amp_pwr_seq #(
    .STARTUP_CYC (20),
    .UNMUTE_SMP  (4),
    .COOLDOWN_CYC(30),
    .FLT_FILT    (4),
    .MAX_RETRY   (3),
    .CNT_W       (18)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .Flt_n     (Flt_n),
    .seq_low   (seq_low),
    .vld       (vld),
    .clr_fault (clr_fault),
    .sht_dwn   (sht_dwn),
    .mute      (mute),
    .fault_cnt (fault_cnt),
    .lockout   (lockout),
    .state     (state)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_vld();
    vld = 1'b1;
    tick(1);
    vld = 1'b0;
    tick(1);
  endtask

  task automatic wait_state(input logic [2:0] s, input int max, input string tag);
    int n = 0;
    while (state !== s && n < max) begin
      tick(1);
      n++;
    end
    chk(tag, 32'(state), 32'(s));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ok;
    rst = 1'b1; Flt_n = 1'b1; seq_low = 1'b0; vld = 1'b0; clr_fault = 1'b0;
    tick(3);
    chk("rst_state",   32'(state),     32'd0);
    chk("rst_sht_dwn", 32'(sht_dwn),   32'd1);
    chk("rst_mute",    32'(mute),      32'd1);
    chk("rst_fcnt",    32'(fault_cnt), 32'd0);
    chk("rst_lockout", 32'(lockout),   32'd0);
    rst = 1'b0;

    // Power-up: 50 cycles in WAIT_Q, then seq_low.
    ok = 1;
    repeat (50) begin
      tick(1);
      if (state !== 3'd0 || sht_dwn !== 1'b1 || mute !== 1'b1) ok = 0;
    end
    chk("waitq_hold", 32'(ok), 32'd1);
    seq_low = 1'b1;
    tick(1);
    chk("pwrup_enter", 32'(state), 32'd1);
    seq_low = 1'b0;
    ok = 1;
    repeat (19) begin
      tick(1);
      if (sht_dwn !== 1'b1 || state !== 3'd1) ok = 0;
    end
    chk("pwrup_hold", 32'(ok), 32'd1);
    tick(1);
    chk("unmute_sht_dwn", 32'(sht_dwn), 32'd0);
    chk("unmute_state",   32'(state),   32'd2);
    chk("unmute_mute",    32'(mute),    32'd1);
    repeat (3) pulse_vld();
    chk("unmute_3vld_mute",  32'(mute),  32'd1);
    chk("unmute_3vld_state", 32'(state), 32'd2);
    vld = 1'b1;
    tick(1);
    vld = 1'b0;
    chk("run_state",   32'(state),   32'd3);
    chk("run_mute",    32'(mute),    32'd0);
    chk("run_sht_dwn", 32'(sht_dwn), 32'd0);

    // A 3-cycle glitch is rejected.
    Flt_n = 1'b0;
    tick(3);
    Flt_n = 1'b1;
    ok = 1;
    repeat (6) begin
      tick(1);
      if (state !== 3'd3 || sht_dwn !== 1'b0 || mute !== 1'b0) ok = 0;
    end
    chk("glitch_reject", 32'(ok), 32'd1);

    // A 4-cycle pulse faults on the 6th edge after the falling edge.
    Flt_n = 1'b0;
    tick(4);
    Flt_n = 1'b1;
    tick(1);
    chk("flt_edge5_state", 32'(state), 32'd3);
    tick(1);
    chk("flt_state",   32'(state),     32'd4);
    chk("flt_sht_dwn", 32'(sht_dwn),   32'd1);
    chk("flt_mute",    32'(mute),      32'd1);
    chk("flt_fcnt",    32'(fault_cnt), 32'd1);

    // Cooldown lasts 30 cycles, then the FSM returns to WAIT_Q.
    ok = 1;
    repeat (29) begin
      tick(1);
      if (state !== 3'd4) ok = 0;
    end
    chk("cooldown_hold", 32'(ok), 32'd1);
    tick(1);
    chk("cooldown_exit", 32'(state), 32'd0);

    // Retry through to RUN; clr_fault outside LOCKOUT is ignored; a clean run clears fault_cnt.
    seq_low = 1'b1;
    tick(1);
    chk("retry_pwrup", 32'(state), 32'd1);
    tick(19);
    chk("retry_pwrup_end", 32'(sht_dwn), 32'd1);
    tick(1);
    chk("retry_unmute", 32'(state), 32'd2);
    repeat (4) pulse_vld();
    chk("retry_run",      32'(state),     32'd3);
    chk("retry_run_fcnt", 32'(fault_cnt), 32'd1);
    clr_fault = 1'b1;
    tick(1);
    clr_fault = 1'b0;
    chk("clr_ignored_fcnt",  32'(fault_cnt), 32'd1);
    chk("clr_ignored_state", 32'(state),     32'd3);
    repeat (3) pulse_vld();
    chk("clean_3vld_fcnt", 32'(fault_cnt), 32'd1);
    vld = 1'b1;
    tick(1);
    vld = 1'b0;
    chk("clean_4vld_fcnt", 32'(fault_cnt), 32'd0);
    tick(1);

    // Persistent fault: the pin stays low across one expiry, then is released near the next.
    Flt_n = 1'b0;
    tick(6);
    chk("persist_enter", 32'(state),     32'd4);
    chk("persist_fcnt",  32'(fault_cnt), 32'd1);
    tick(31);
    chk("persist_restart1", 32'(state), 32'd4);
    tick(27);
    Flt_n = 1'b1;
    tick(3);
    chk("persist_restart2", 32'(state), 32'd4);
    tick(28);
    chk("persist_hold", 32'(state), 32'd4);
    tick(1);
    chk("persist_exit", 32'(state), 32'd0);

    // Async reset in the middle of UNMUTE.
    tick(1);
    chk("rstmid_pwrup", 32'(state), 32'd1);
    tick(20);
    chk("rstmid_unmute", 32'(state), 32'd2);
    repeat (2) pulse_vld();
    chk("rstmid_pre_fcnt", 32'(fault_cnt), 32'd1);
    #3 rst = 1'b1;
    #1;
    chk("rstmid_sht_dwn", 32'(sht_dwn),   32'd1);
    chk("rstmid_mute",    32'(mute),      32'd1);
    chk("rstmid_state",   32'(state),     32'd0);
    chk("rstmid_fcnt",    32'(fault_cnt), 32'd0);
    tick(2);
    rst = 1'b0;

    // Lockout: three faults, each during PWR_UP.
    for (int k = 1; k <= 3; k++) begin
      wait_state(3'd1, 40, "lock_wait_pwrup");
      Flt_n = 1'b0;
      tick(4);
      Flt_n = 1'b1;
      tick(2);
      chk("lock_fault_state", 32'(state),     32'd4);
      chk("lock_fault_fcnt",  32'(fault_cnt), 32'(k));
    end
    tick(1);
    chk("lockout_state",   32'(state),   32'd5);
    chk("lockout_flag",    32'(lockout), 32'd1);
    chk("lockout_sht_dwn", 32'(sht_dwn), 32'd1);
    chk("lockout_mute",    32'(mute),    32'd1);
    ok = 1;
    repeat (1000) begin
      tick(1);
      if (state !== 3'd5 || sht_dwn !== 1'b1 || lockout !== 1'b1) ok = 0;
    end
    chk("lockout_hold", 32'(ok), 32'd1);
    clr_fault = 1'b1;
    tick(1);
    clr_fault = 1'b0;
    chk("clr_state",   32'(state),     32'd0);
    chk("clr_fcnt",    32'(fault_cnt), 32'd0);
    chk("clr_lockout", 32'(lockout),   32'd0);
    tick(1);
    chk("clr_restart", 32'(state), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
